fib_engine: RTL and testbench
=============================

FIB_ENGINE -- requirements
Module: fib_engine

Interface
REQ-001 Parameter N_W, default 5, width of the index input n.
REQ-002 Parameter D_W, default 16, width of the result datapath.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 start  input  1  request to compute F(n); sampled only in IDLE.
REQ-006 abort  input  1  cancels a computation in progress.
REQ-007 n  input  N_W  Fibonacci index, unsigned; sampled with start.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  one-cycle pulse; result and overflow valid.
REQ-010 result  output  D_W  F(n), held stable until the next accepted start.
REQ-011 overflow  output  1  set when F(n) does not fit in D_W bits; held with result.

Function
REQ-012 The FSM SHALL have states IDLE, CASE_0, CALC and FINAL; any illegal encoding SHALL go to IDLE on the next clock.
REQ-013 IDLE: start=1 SHALL latch n and go to CASE_0; start in any other state SHALL be ignored.
REQ-014 CASE_0: n=0 SHALL load a=0 and b=0; otherwise it SHALL load a=0, b=1 and count=1; then go to FINAL if n<=1, else go to CALC.
REQ-015 CALC: each cycle SHALL perform a<=b, b<=a+b and count<=count+1; when count+1==n it SHALL go to FINAL.
REQ-016 FINAL: done=1 for exactly one cycle, result<=b, then go to IDLE.
REQ-017 Latency from the start cycle (cycle 0): done SHALL be at cycle 2 for n<=1 and at cycle n+1 for n>=2.
REQ-018 The adder SHALL be D_W+1 bits wide; a carry out SHALL set an internal sticky ovf bit, cleared in CASE_0.
REQ-019 overflow SHALL be updated from ovf in FINAL only.
REQ-020 abort=1 in CASE_0 or CALC SHALL go to IDLE next cycle with no done pulse, and result and overflow SHALL be unchanged.
REQ-021 abort SHALL take priority over the CALC-to-FINAL transition, and abort in IDLE or FINAL SHALL have no effect.
REQ-022 If start and abort are both high in IDLE, start SHALL be accepted.
REQ-023 count SHALL be N_W bits wide and cannot wrap, because n <= 2^N_W-1.

Reset
REQ-024 While rst=0, the state SHALL be IDLE and busy, done, overflow, result, a, b, count and ovf SHALL all be 0, asynchronously.
REQ-025 Reset asserted mid-computation SHALL discard the computation, and no done SHALL follow reset release.
REQ-026 The first start SHALL be accepted on the first clock edge after rst deasserts.

Configuration
REQ-027 Macro FIB_SATURATE_EN defined: once ovf is set, b SHALL be forced to all-ones and result SHALL read 2^D_W-1.
REQ-028 Macro FIB_SATURATE_EN undefined: b SHALL wrap modulo 2^D_W.
REQ-029 overflow SHALL be reported identically with or without FIB_SATURATE_EN.

Structure
REQ-030 Package fib_pkg SHALL hold the state enum typedef and the default values of N_W and D_W.
REQ-031 Sub-module fib_datapath SHALL contain registers a and b, the D_W+1 adder and the sticky ovf bit; fib_engine SHALL contain the FSM and count.

Verification
REQ-032 D_W=16: n=0 -> done at cycle 2, result=0, overflow=0.
REQ-033 n=1 -> done at cycle 2, result=1; n=10 -> done at cycle 11, result=55, overflow=0.
REQ-034 n=24 -> result=46368, overflow=0; n=25 -> overflow=1, result=9489 without FIB_SATURATE_EN, 65535 with it.
REQ-035 n=10 with start re-pulsed at cycle 4 -> the second start is ignored and a single done occurs at cycle 11.
REQ-036 Abort at cycle 5 of an n=20 run -> busy=0 at cycle 6, no done, result keeps its previous value.
REQ-037 rst=0 at cycle 3 of an n=15 run -> all outputs 0 immediately; after release, n=2 -> done at cycle 3, result=1.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci engine: state encoding, default widths
// and small decode helpers.
package fib_pkg;

  localparam int N_W_DEF = 5;
  localparam int D_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CASE_0 = 2'd1,
    ST_CALC   = 2'd2,
    ST_FINAL  = 2'd3
  } fib_state_e;

  function automatic logic fib_is_busy(input fib_state_e s);
    return (s != ST_IDLE);
  endfunction

  function automatic logic fib_is_done(input fib_state_e s);
    return (s == ST_FINAL);
  endfunction

endpackage

// File: rtl/fib_if.sv
// Request/response bundle between a requester and the Fibonacci engine.
interface fib_if #(
  parameter int N_W = 5,
  parameter int D_W = 16
) ();

  // Handshake: start is a request that is accepted only while busy=0; once
  // accepted, busy stays high until the one-cycle done pulse, during which
  // result/overflow are valid. result/overflow then hold until the next
  // accepted start. abort cancels an accepted request before done.
  logic           start;
  logic           abort;
  logic [N_W-1:0] n;
  logic           busy;
  logic           done;
  logic [D_W-1:0] result;
  logic           overflow;

  modport master (
    output start, abort, n,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, abort, n,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/fib_datapath.sv
// Fibonacci datapath: a/b term registers, D_W+1-bit adder and sticky overflow.
// Build with FIB_SATURATE_EN defined to clamp b to all-ones once overflow occurs.
module fib_datapath #(
  parameter int D_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_init,
  input  logic           i_n_zero,
  input  logic           i_step,
  output logic [D_W-1:0] o_b,
  output logic           o_ovf
);

  logic [D_W-1:0] r_a;
  logic [D_W-1:0] r_b;
  logic           r_ovf;
  logic [D_W:0]   w_sum;
  logic           w_ovf_nxt;
  logic [D_W-1:0] w_b_nxt;

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_ovf_nxt = r_ovf | w_sum[D_W];

`ifdef FIB_SATURATE_EN
  assign w_b_nxt = w_ovf_nxt ? {D_W{1'b1}} : w_sum[D_W-1:0];
`else
  assign w_b_nxt = w_sum[D_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ovf <= 1'b0;
    end else if (i_init) begin
      // F(0) needs b=0; every other index seeds the pair (0, 1).
      r_a   <= '0;
      r_b   <= i_n_zero ? '0 : D_W'(1);
      r_ovf <= 1'b0;
    end else if (i_step) begin
      r_a   <= r_b;
      r_b   <= w_b_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign o_b   = r_b;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/fib_engine.sv
// Fibonacci engine top: control FSM, index latch, step counter and result
// holding registers; arithmetic lives in fib_datapath (see FIB_SATURATE_EN).
module fib_engine
  import fib_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  fib_if.slave       bus,
  output fib_state_e o_dbg_state
);

  fib_state_e     r_state;
  fib_state_e     w_state_nxt;
  logic [N_W-1:0] r_n;
  logic [N_W-1:0] r_count;
  logic [N_W-1:0] w_count_inc;
  logic [D_W-1:0] r_result;
  logic           r_overflow;
  logic           w_init;
  logic           w_step;
  logic           w_n_zero;
  logic [D_W-1:0] w_b;
  logic           w_ovf;

  assign w_count_inc = r_count + N_W'(1);
  assign w_n_zero    = (r_n == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_CASE_0;
        end
      end
      ST_CASE_0: begin
        w_init = 1'b1;
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_n <= N_W'(1)) begin
          w_state_nxt = ST_FINAL;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        // abort outranks the exit to FINAL so a cancelled run never pulses done.
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_count_inc == r_n) begin
            w_state_nxt = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n     <= '0;
      r_count <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.start) begin
        r_n <= bus.n;
      end
      if (w_init) begin
        r_count <= N_W'(1);
      end else if (w_step) begin
        r_count <= w_count_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_FINAL) begin
      r_result   <= w_b;
      r_overflow <= w_ovf;
    end
  end

  fib_datapath #(
    .D_W (D_W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_init   (w_init),
    .i_n_zero (w_n_zero),
    .i_step   (w_step),
    .o_b      (w_b),
    .o_ovf    (w_ovf)
  );

  // During FINAL the fresh value is shown directly so done and result coincide.
  assign bus.busy     = fib_is_busy(r_state);
  assign bus.done     = fib_is_done(r_state);
  assign bus.result   = (r_state == ST_FINAL) ? w_b : r_result;
  assign bus.overflow = (r_state == ST_FINAL) ? w_ovf : r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fib_engine.sv
// Directed bench for fib_engine: latency, results, overflow, abort and reset.
module tb_fib_engine;
  import fib_pkg::*;

  localparam int N_W = 5;
  localparam int D_W = 16;
`ifdef FIB_SATURATE_EN
  localparam logic [D_W-1:0] EXP_F25 = 16'd65535;
`else
  localparam logic [D_W-1:0] EXP_F25 = 16'd9489;
`endif

  logic       clk;
  logic       rst;
  fib_state_e dbg_state;
  int         n_cmp;
  int         n_fail;

  fib_if #(.N_W(N_W), .D_W(D_W)) bus ();

  fib_engine #(
    .N_W (N_W),
    .D_W (D_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; that half-cycle is cycle 0 (start high).
  // rep_c: cycle to re-pulse start; ab_c: cycle to hold abort (0 = with start).
  task automatic run(input string tag, input int nv, input int rep_c, input int ab_c,
                     input int exp_cyc, input int exp_dones,
                     input logic [D_W-1:0] exp_res, input logic exp_ovf);
    int first_c;
    int n_done;
    logic [D_W-1:0] res_at_done;
    logic ovf_at_done;
    first_c     = -1;
    n_done      = 0;
    res_at_done = '0;
    ovf_at_done = 1'b0;
    bus.start = 1'b1;
    bus.n     = N_W'(nv);
    bus.abort = (ab_c == 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == rep_c);
      bus.abort = (c == ab_c);
      if (c == 1) check({tag, " busy@1"}, 32'(bus.busy), 32'd1);
      if (ab_c > 0 && c == ab_c + 1) check({tag, " busy_after_abort"}, 32'(bus.busy), 32'd0);
      if (bus.done) begin
        n_done++;
        if (first_c < 0) begin
          first_c     = c;
          res_at_done = bus.result;
          ovf_at_done = bus.overflow;
        end
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check({tag, " done_count"}, 32'(n_done), 32'(exp_dones));
    if (exp_dones > 0) begin
      check({tag, " done_cycle"}, 32'(first_c), 32'(exp_cyc));
      check({tag, " result@done"}, 32'(res_at_done), 32'(exp_res));
      check({tag, " overflow@done"}, 32'(ovf_at_done), 32'(exp_ovf));
    end
    check({tag, " result_held"}, 32'(bus.result), 32'(exp_res));
    check({tag, " overflow_held"}, 32'(bus.overflow), 32'(exp_ovf));
  endtask

  initial begin
    int n_done;
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.n     = '0;

    @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));

    // Start is raised together with reset release: the first edge must accept it.
    rst = 1'b1;
    run("n0", 0, -1, -1, 2, 1, 16'd0, 1'b0);
    run("n1", 1, -1, -1, 2, 1, 16'd1, 1'b0);
    run("n10", 10, -1, -1, 11, 1, 16'd55, 1'b0);
    run("n24", 24, -1, -1, 25, 1, 16'd46368, 1'b0);
    run("n25", 25, -1, -1, 26, 1, EXP_F25, 1'b1);
    run("n10_repulse", 10, 4, -1, 11, 1, 16'd55, 1'b0);
    run("n20_abort", 20, -1, 5, 0, 0, 16'd55, 1'b0);
    run("n3_start_abort", 3, -1, 0, 4, 1, 16'd2, 1'b0);
    run("n1_abort_final", 1, -1, 2, 2, 1, 16'd1, 1'b0);

    // Asynchronous reset in the middle of an n=15 run.
    bus.start = 1'b1;
    bus.n     = N_W'(15);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst result", 32'(bus.result), 32'd0);
    check("midrst overflow", 32'(bus.overflow), 32'd0);
    check("midrst state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst no_done", 32'(n_done), 32'd0);
    run("n2_after_rst", 2, -1, -1, 3, 1, 16'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
